complete_arbiter: RTL and testbench
===================================

# complete_arbiter

Writeback-side arbiter feeding the physical register file's single write port. It buffers completed results from NUM_FU functional units in small per-unit FIFOs and grants one result per cycle, round-robin. The granted result is driven as a registered write (enable, physical tag, data) to the PRF and the issue-stage forwarding path. It also gives each functional unit a valid/ready handshake, so units stall instead of dropping results.

## Interface
- NUM_FU, 4, number of functional-unit result ports (≥2)
- DEPTH, 2, entries per per-unit FIFO (power of 2, ≥2)
- XLEN, 32, data width
- PREG_W, 6, physical tag width (`PHYS_REG_SZ` = 64 registers)

- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- squash  in  1  synchronous flush (branch mispredict), active-high
- fu_valid  in  NUM_FU  result valid per unit
- fu_tag  in  NUM_FU×PREG_W  destination physical register per unit
- fu_data  in  NUM_FU×XLEN  result value per unit
- fu_ready  out  NUM_FU  unit i's FIFO can accept this cycle
- write_en  out  1  PRF write strobe (registered)
- write_tag  out  PREG_W  PRF write index (registered)
- write_data  out  XLEN  PRF write value (registered)

## Operation
- Per unit i: FIFO with count_i in 0..DEPTH, head/tail pointers wrap modulo DEPTH.
- fu_ready[i] = (count_i < DEPTH). It depends only on registered count, with no same-cycle pop-through. It is forced to 0 while reset is asserted.
- Push: fu_valid[i] && fu_ready[i] && !squash at posedge → {tag,data} written at tail, tail++ and count_i++.
- Arbitration (combinational, every cycle): among FIFOs with count_i > 0, grant the first index found scanning from rr_ptr upward, wrapping mod NUM_FU. At most one grant per cycle.
- On grant g: head of FIFO g popped, count_g-- and rr_ptr ← (g+1) mod NUM_FU. With no grant, rr_ptr is unchanged.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. A full FIFO still shows ready=0 that cycle.
- Output register at posedge:
  - grant with tag ≠ 0: write_en←1, write_tag/write_data←head entry.
  - grant with tag = 0 (no-destination result): entry consumes the slot, write_en←0, write_tag/write_data←0.
  - no grant: write_en←0, write_tag/write_data hold their previous value.
- write_en is high for exactly one cycle per granted nonzero-tag result. The PRF never backpressures.
- Squash at posedge:
  - all counts/pointers ← 0; write_en←0; rr_ptr←0.
  - results presented that cycle are dropped even where fu_ready=1.
  - a write already registered (write_en=1 during the squash cycle) still completes that cycle.
- Reset (asserted low, any time, asynchronous): all FIFOs empty, rr_ptr=0, write_en=0, write_tag=0, write_data=0, fu_ready=0. After deassertion, fu_ready=all 1 and the next edge may accept results.

## Timing
- Minimum latency: result pushed at edge N is in FIFO during cycle N→N+1. If granted, it is registered at edge N+1, so write_en is visible in cycle N+1→N+2.
- Throughput: one PRF write per cycle aggregate. Per unit, sustained 1/cycle only when it is the sole requester.
- Fairness: a nonempty FIFO is granted within NUM_FU cycles.
- Ordering: results from the same unit are written in acceptance order. No ordering guarantee across units.
- No combinational path from fu_valid to fu_ready or to write_*.

## Test plan
- Single result: reset released, unit 1 presents tag 5, data 0xDEADBEEF at edge 0 → fu_ready[1]=1. write_en=1, write_tag=5, write_data=0xDEADBEEF in cycle 1→2 only; write_en=0 after.
- Contention: all 4 units push tags 10,11,12,13 at the same edge with rr_ptr=0 → writes of tags 10,11,12,13 on four consecutive cycles. rr_ptr ends at 0.
- Backpressure: unit 2 pushes every cycle while units 0,1,3 also hold results → FIFO 2 fills (count=2) and fu_ready[2]=0. No result lost, and unit-2 tags appear in push order.
- Zero tag: unit 0 pushes tag 0 then tag 7 → one cycle with write_en=0, next cycle write_en=1 with tag 7.
- Squash: three units hold entries and squash asserted for one edge → no write_en afterwards. fu_ready=all 1 the next cycle, and new pushes after that are accepted with normal 2-cycle latency.
- Reset mid-drain: reset driven low asynchronously with FIFOs nonempty and write_en=1 → write_en=0, write_tag=0, write_data=0 and fu_ready=0 immediately. After release, no stale result is ever written.

Source files
------------

// File: rtl/complete_arbiter.sv
`default_nettype none
// complete_arbiter -- per-unit result FIFOs, round-robin grant onto the single PRF write port.
// rev 1.0
module complete_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int PREG_W = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     squash_i,
  input  logic [NUM_FU-1:0]        fu_valid_i,
  input  logic [NUM_FU*PREG_W-1:0] fu_tag_i,
  input  logic [NUM_FU*XLEN-1:0]   fu_data_i,
  output logic [NUM_FU-1:0]        fu_ready_o,
  output logic                     write_en_o,
  output logic [PREG_W-1:0]        write_tag_o,
  output logic [XLEN-1:0]          write_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(NUM_FU);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FU - 1);

  logic [NUM_FU-1:0]             nonempty;
  logic [NUM_FU-1:0]             push;
  logic [NUM_FU-1:0]             pop;
  logic [NUM_FU-1:0][PREG_W-1:0] head_tag;
  logic [NUM_FU-1:0][XLEN-1:0]   head_data;

  logic              grant_valid;
  logic              hi_found;
  logic [IDX_W-1:0]  grant_hi;
  logic [IDX_W-1:0]  grant_lo;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_d;
  logic [PREG_W-1:0] sel_tag;
  logic [XLEN-1:0]   sel_data;

  logic              write_en_q;
  logic [PREG_W-1:0] write_tag_q;
  logic [XLEN-1:0]   write_data_q;

  generate
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      logic [CNT_W-1:0]  count_q;
      logic [CNT_W-1:0]  count_d;
      logic [PTR_W-1:0]  head_q;
      logic [PTR_W-1:0]  tail_q;
      logic [PREG_W-1:0] tag_mem_q  [DEPTH];
      logic [XLEN-1:0]   data_mem_q [DEPTH];

      // Ready comes only from registered occupancy so fu_valid never loops back into it.
      assign fu_ready_o[i] = rst_ni & (count_q < FULL_CNT);
      assign push[i]       = fu_valid_i[i] & fu_ready_o[i] & ~squash_i;
      assign pop[i]        = grant_valid & (grant_idx == IDX_W'(i));
      assign nonempty[i]   = (count_q != '0);
      assign head_tag[i]   = tag_mem_q[head_q];
      assign head_data[i]  = data_mem_q[head_q];

      always_comb begin
        count_d = count_q;
        if (push[i] && !pop[i]) begin
          count_d = count_q + 1'b1;
        end else if (!push[i] && pop[i]) begin
          count_d = count_q - 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          count_q <= '0;
          head_q  <= '0;
          tail_q  <= '0;
        end else if (squash_i) begin
          count_q <= '0;
          head_q  <= '0;
          tail_q  <= '0;
        end else begin
          count_q <= count_d;
          if (push[i]) tail_q <= tail_q + 1'b1;
          if (pop[i])  head_q <= head_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (push[i]) begin
          tag_mem_q[tail_q]  <= fu_tag_i[i*PREG_W +: PREG_W];
          data_mem_q[tail_q] <= fu_data_i[i*XLEN +: XLEN];
        end
      end
    end
  endgenerate

  // Two-pass scan: lowest requester at or above rr_ptr wins, else lowest overall (the wrap).
  always_comb begin
    grant_hi    = '0;
    grant_lo    = '0;
    hi_found    = 1'b0;
    grant_valid = |nonempty;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (nonempty[i]) begin
        grant_lo = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr_q) begin
          grant_hi = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant_idx = hi_found ? grant_hi : grant_lo;
    rr_ptr_d  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    sel_tag   = head_tag[grant_idx];
    sel_data  = head_data[grant_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      write_en_q   <= 1'b0;
      write_tag_q  <= '0;
      write_data_q <= '0;
    end else if (squash_i) begin
      rr_ptr_q   <= '0;
      write_en_q <= 1'b0;
    end else if (grant_valid) begin
      rr_ptr_q <= rr_ptr_d;
      // Tag 0 means no destination: the slot is consumed but nothing is written.
      if (sel_tag != '0) begin
        write_en_q   <= 1'b1;
        write_tag_q  <= sel_tag;
        write_data_q <= sel_data;
      end else begin
        write_en_q   <= 1'b0;
        write_tag_q  <= '0;
        write_data_q <= '0;
      end
    end else begin
      write_en_q <= 1'b0;
    end
  end

  assign write_en_o   = write_en_q;
  assign write_tag_o  = write_tag_q;
  assign write_data_o = write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_complete_arbiter.sv
`default_nettype none
// tb_complete_arbiter -- directed stimulus with a write-port scoreboard for complete_arbiter.
// rev 1.0
module tb_complete_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        squash = 1'b0;
  logic [3:0]  fu_valid = '0;
  logic [23:0] fu_tag = '0;
  logic [127:0] fu_data = '0;
  logic [3:0]  fu_ready;
  logic        write_en;
  logic [5:0]  write_tag;
  logic [31:0] write_data;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  complete_arbiter #(
    .NUM_FU(4), .DEPTH(2), .XLEN(32), .PREG_W(6)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .squash_i    (squash),
    .fu_valid_i  (fu_valid),
    .fu_tag_i    (fu_tag),
    .fu_data_i   (fu_data),
    .fu_ready_o  (fu_ready),
    .write_en_o  (write_en),
    .write_tag_o (write_tag),
    .write_data_o(write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int u, input logic v, input logic [5:0] t, input logic [31:0] d);
    fu_valid[u]       = v;
    fu_tag[u*6 +: 6]  = t;
    fu_data[u*32 +: 32] = d;
  endtask

  task automatic expect_wr(input logic [5:0] t, input logic [31:0] d);
    exp_q.push_back({t, d});
  endtask

  // Monitor: every PRF write must match the next expected entry, in order.
  always @(negedge clk) begin
    if (rst_n && write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual tag=%0d data=%0h required=no write", write_tag, write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("scoreboard_write", {26'd0, write_tag, write_data}, {26'd0, e.tag, e.data});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stall;
    logic rdy;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_en",    {63'd0, write_en}, 64'd0);
    check("reset_tag",   {58'd0, write_tag}, 64'd0);
    check("reset_data",  {32'd0, write_data}, 64'd0);
    check("reset_ready", {60'd0, fu_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {60'd0, fu_ready}, 64'hF);

    // Single result with 2-cycle latency
    set_fu(1, 1'b1, 6'd5, 32'hDEADBEEF);
    expect_wr(6'd5, 32'hDEADBEEF);
    check("t1_ready1", {63'd0, fu_ready[1]}, 64'd1);
    tick();
    fu_valid = '0;
    @(negedge clk); check("t1_lat_cycle0", {63'd0, write_en}, 64'd0);
    @(negedge clk); check("t1_lat_cycle1", {63'd0, write_en}, 64'd1);
    @(negedge clk); check("t1_after",      {63'd0, write_en}, 64'd0);

    // Return rr_ptr to 0
    squash = 1'b1; tick(); squash = 1'b0;

    // Contention: all four units at once
    for (int u = 0; u < 4; u++) begin
      set_fu(u, 1'b1, 6'(10 + u), 32'h100 + u);
      expect_wr(6'(10 + u), 32'h100 + u);
    end
    tick();
    fu_valid = '0;
    @(negedge clk); check("t2_first_idle", {63'd0, write_en}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("t2_consecutive", {63'd0, write_en}, 64'd1);
    end
    @(negedge clk); check("t2_done", {63'd0, write_en}, 64'd0);
    // rr_ptr back at 0: unit 0 must beat unit 3
    set_fu(0, 1'b1, 6'd20, 32'h200);
    set_fu(3, 1'b1, 6'd23, 32'h203);
    expect_wr(6'd20, 32'h200);
    expect_wr(6'd23, 32'h203);
    tick();
    fu_valid = '0;
    repeat (4) @(negedge clk);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // Zero tag consumes a slot without writing
    set_fu(0, 1'b1, 6'd0, 32'h55);
    tick();
    set_fu(0, 1'b1, 6'd7, 32'h77);
    expect_wr(6'd7, 32'h77);
    tick();
    fu_valid = '0;
    @(negedge clk);
    check("t4_zero_en",   {63'd0, write_en}, 64'd0);
    check("t4_zero_tag",  {58'd0, write_tag}, 64'd0);
    check("t4_zero_data", {32'd0, write_data}, 64'd0);
    @(negedge clk);
    check("t4_tag7_en",  {63'd0, write_en}, 64'd1);
    check("t4_tag7_tag", {58'd0, write_tag}, 64'd7);
    @(negedge clk);

    // Backpressure on unit 2
    squash = 1'b1; tick(); squash = 1'b0;
    set_fu(0, 1'b1, 6'd30, 32'h1030);
    set_fu(1, 1'b1, 6'd31, 32'h1031);
    set_fu(3, 1'b1, 6'd33, 32'h1033);
    expect_wr(6'd30, 32'h1030);
    expect_wr(6'd31, 32'h1031);
    expect_wr(6'd40, 32'h2000);
    expect_wr(6'd33, 32'h1033);
    expect_wr(6'd41, 32'h2001);
    expect_wr(6'd42, 32'h2002);
    expect_wr(6'd43, 32'h2003);
    expect_wr(6'd44, 32'h2004);
    expect_wr(6'd45, 32'h2005);
    n = 0;
    stall = 0;
    for (int it = 0; it < 40 && n < 6; it++) begin
      set_fu(2, 1'b1, 6'(40 + n), 32'h2000 + n);
      rdy = fu_ready[2];
      if (!rdy) stall++;
      tick();
      if (it == 0) begin
        fu_valid[0] = 1'b0;
        fu_valid[1] = 1'b0;
        fu_valid[3] = 1'b0;
      end
      if (it == 1) check("t3_ready_full", {60'd0, fu_ready}, 64'b1011);
      if (rdy) n++;
    end
    fu_valid = '0;
    check("t3_pushed",      64'(n), 64'd6);
    check("t3_stall_cycles", 64'(stall), 64'd3);
    repeat (4) @(negedge clk);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Squash: one in-flight write completes, everything else is dropped
    set_fu(0, 1'b1, 6'd50, 32'h1050);
    set_fu(1, 1'b1, 6'd51, 32'h1051);
    set_fu(3, 1'b1, 6'd53, 32'h1053);
    expect_wr(6'd53, 32'h1053);
    tick();
    fu_valid = '0;
    set_fu(2, 1'b1, 6'd52, 32'h1052);
    tick();
    set_fu(2, 1'b1, 6'd60, 32'h60);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    check("t5_squash_en",    {63'd0, write_en}, 64'd0);
    check("t5_squash_ready", {60'd0, fu_ready}, 64'hF);
    repeat (5) @(negedge clk);
    set_fu(1, 1'b1, 6'd61, 32'h61);
    expect_wr(6'd61, 32'h61);
    tick();
    fu_valid = '0;
    @(negedge clk); check("t5_lat_cycle0", {63'd0, write_en}, 64'd0);
    @(negedge clk); check("t5_lat_cycle1", {63'd0, write_en}, 64'd1);
    @(negedge clk);

    // Reset mid-drain
    for (int u = 0; u < 4; u++) set_fu(u, 1'b1, 6'(70 + u), 32'h1070 + u);
    expect_wr(6'd72, 32'h1072);
    tick();
    fu_valid = '0;
    tick();
    @(negedge clk);
    check("t6_pre_reset_en", {63'd0, write_en}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_en",    {63'd0, write_en}, 64'd0);
    check("t6_rst_tag",   {58'd0, write_tag}, 64'd0);
    check("t6_rst_data",  {32'd0, write_data}, 64'd0);
    check("t6_rst_ready", {60'd0, fu_ready}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("t6_ready_release", {60'd0, fu_ready}, 64'hF);
    repeat (8) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
